// File: rtl/e_delay_line.sv
// =============================================================================
// e_delay_line : D-stage enabled, valid-tracked delay line with tap and count
// Revision     : 1.0
// =============================================================================
`default_nettype none

module e_delay_line #(
  parameter  int B  = 18,
  parameter  int D  = 4,
  localparam int TW = $clog2(D),
  localparam int CW = $clog2(D + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic          clr_i,
  input  logic [B-1:0]  in_i,
  input  logic          in_valid_i,
  input  logic [TW-1:0] tap_sel_i,
  output logic [B-1:0]  out_o,
  output logic          out_valid_o,
  output logic [B-1:0]  tap_o,
  output logic          tap_valid_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [B-1:0]  data_q [D];
  logic [D-1:0]  valid_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Entering and leaving words cancel; bounds hold by construction.
  always_comb begin
    count_d = count_q + CW'(in_valid_i) - CW'(valid_q[D-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < D; i++) data_q[i] <= '0;
      valid_q <= '0;
      count_q <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < D; i++) data_q[i] <= '0;
      valid_q <= '0;
      count_q <= '0;
    end else if (en_i) begin
      data_q[0] <= in_i;
      for (int i = 1; i < D; i++) data_q[i] <= data_q[i-1];
      valid_q <= {valid_q[D-2:0], in_valid_i};
      count_q <= count_d;
    end
  end

  generate
    if ((2 ** TW) == D) begin : g_tap_pow2
      always_comb begin
        tap_o       = data_q[tap_sel_i];
        tap_valid_o = valid_q[tap_sel_i];
      end
    end else begin : g_tap_guarded
      // Selects past the last stage read as an empty, invalid stage.
      always_comb begin
        tap_o       = '0;
        tap_valid_o = 1'b0;
        if (tap_sel_i < TW'(D)) begin
          tap_o       = data_q[tap_sel_i];
          tap_valid_o = valid_q[tap_sel_i];
        end
      end
    end
  endgenerate

  assign out_o       = data_q[D-1];
  assign out_valid_o = valid_q[D-1];
  assign count_o     = count_q;
  assign full_o      = (count_q == CW'(D));
  assign empty_o     = (count_q == '0);

endmodule

`default_nettype wire

// File: tb/tb_e_delay_line.sv
// =============================================================================
// tb_e_delay_line : scoreboard bench for e_delay_line (B=18, D=4)
// Revision        : 1.0
// =============================================================================
`default_nettype none

module tb_e_delay_line;

  localparam int B  = 18;
  localparam int D  = 4;
  localparam int TW = $clog2(D);
  localparam int CW = $clog2(D + 1);
  localparam int ST = B + CW + 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          en_i;
  logic          clr_i;
  logic [B-1:0]  in_i;
  logic          in_valid_i;
  logic [TW-1:0] tap_sel_i;
  logic [B-1:0]  out_o;
  logic          out_valid_o;
  logic [B-1:0]  tap_o;
  logic          tap_valid_o;
  logic [CW-1:0] count_o;
  logic          full_o;
  logic          empty_o;

  int checks   = 0;
  int failures = 0;

  // Scoreboard: front = oldest word (last stage), back = newest (stage 0).
  logic [B:0] mq[$];

  always #5 clk = ~clk;

  e_delay_line #(.B(B), .D(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .en_i       (en_i),
    .clr_i      (clr_i),
    .in_i       (in_i),
    .in_valid_i (in_valid_i),
    .tap_sel_i  (tap_sel_i),
    .out_o      (out_o),
    .out_valid_o(out_valid_o),
    .tap_o      (tap_o),
    .tap_valid_o(tap_valid_o),
    .count_o    (count_o),
    .full_o     (full_o),
    .empty_o    (empty_o)
  );

  wire [ST-1:0] w_status = {out_valid_o, out_o, count_o, full_o, empty_o};

  task automatic model_clear();
    mq.delete();
    repeat (D) mq.push_back('0);
  endtask

  function automatic logic [ST-1:0] exp_status();
    int n;
    n = 0;
    for (int i = 0; i < D; i++) n += int'(mq[i][B]);
    return {mq[0][B], mq[0][B-1:0], CW'(n), (n == D), (n == 0)};
  endfunction

  function automatic logic [B:0] exp_tap(input int k);
    return mq[D-1-k];
  endfunction

  // Drive one cycle of inputs, advance the scoreboard at the edge, settle.
  task automatic step(input logic e, input logic c, input logic [B-1:0] d, input logic v);
    en_i = e; clr_i = c; in_i = d; in_valid_i = v;
    @(posedge clk);
    if (c) model_clear();
    else if (e) begin
      mq.push_back({v, d});
      void'(mq.pop_front());
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en_i = 1'b0; clr_i = 1'b0; in_i = 18'd12; in_valid_i = 1'b0; tap_sel_i = '0;
    #17 rst = 1'b1;
    #1;
    checks++;
    if (w_status !== {1'b0, 18'h0, 3'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_async: got %h expected %h", w_status, {1'b0, 18'h0, 3'd0, 1'b0, 1'b1});
    end
    checks++;
    if ({tap_valid_o, tap_o} !== 19'h0) begin
      failures++;
      $display("FAIL reset_tap: got %h expected 0", {tap_valid_o, tap_o});
    end
    #11 rst = 1'b0;
    model_clear();
  endtask

  task automatic test_fill();
    logic [B-1:0] words [7];
    words = '{18'd27, 18'd192, 18'd5, 18'd9, 18'd0, 18'd0, 18'd0};
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b0, words[i], (i < 4));
      checks++;
      if (w_status !== exp_status()) begin
        failures++;
        $display("FAIL fill_edge%0d: got %h expected %h", i + 1, w_status, exp_status());
      end
      if (i >= 3) begin
        checks++;
        if ({out_valid_o, out_o} !== {1'b1, words[i-3]}) begin
          failures++;
          $display("FAIL fill_out%0d: got %h expected %h", i + 1, {out_valid_o, out_o}, {1'b1, words[i-3]});
        end
      end
      if (i == 3) begin
        checks++;
        if ({count_o, full_o} !== {3'd4, 1'b1}) begin
          failures++;
          $display("FAIL fill_full: got %h expected %h", {count_o, full_o}, {3'd4, 1'b1});
        end
      end
    end
  endtask

  task automatic test_hold();
    step(1'b0, 1'b1, 18'd0, 1'b0);
    step(1'b1, 1'b0, 18'd27, 1'b1);
    step(1'b1, 1'b0, 18'd192, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 18'(1000 + i), 1'b1);
      checks++;
      if (w_status !== exp_status() || count_o !== 3'd2) begin
        failures++;
        $display("FAIL hold_cycle%0d: got %h expected %h", i, w_status, exp_status());
      end
    end
    step(1'b1, 1'b0, 18'd7, 1'b0);
    step(1'b1, 1'b0, 18'd8, 1'b0);
    checks++;
    if ({out_valid_o, out_o} !== {1'b1, 18'd27} || w_status !== exp_status()) begin
      failures++;
      $display("FAIL hold_resume: got %h expected %h", {out_valid_o, out_o}, {1'b1, 18'd27});
    end
  endtask

  task automatic test_bubbles();
    logic [CW-1:0] exp_cnt [8];
    exp_cnt = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2};
    step(1'b0, 1'b1, 18'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 18'(50 + i), (i % 2 == 0));
      checks++;
      if (count_o !== exp_cnt[i] || out_valid_o !== (i >= 3 && i % 2 == 1)) begin
        failures++;
        $display("FAIL bubble_edge%0d: got cnt=%0d ov=%b expected cnt=%0d ov=%b",
                 i + 1, count_o, out_valid_o, exp_cnt[i], (i >= 3 && i % 2 == 1));
      end
      checks++;
      if (w_status !== exp_status()) begin
        failures++;
        $display("FAIL bubble_model%0d: got %h expected %h", i + 1, w_status, exp_status());
      end
    end
  endtask

  task automatic test_clear();
    for (int i = 0; i < D; i++) step(1'b1, 1'b0, 18'(10 + i), 1'b1);
    step(1'b1, 1'b1, 18'd77, 1'b1);
    checks++;
    if ({count_o, full_o, empty_o, out_valid_o, out_o} !== {3'd0, 1'b0, 1'b1, 1'b0, 18'd0}) begin
      failures++;
      $display("FAIL clear_status: got %h expected %h", w_status, exp_status());
    end
    for (int k = 0; k < D; k++) begin
      tap_sel_i = TW'(k);
      #1;
      checks++;
      if ({tap_valid_o, tap_o} !== 19'h0) begin
        failures++;
        $display("FAIL clear_tap%0d: got %h expected 0", k, {tap_valid_o, tap_o});
      end
    end
  endtask

  task automatic test_tap_async_reset();
    for (int i = 1; i <= D; i++) step(1'b1, 1'b0, 18'(i), 1'b1);
    for (int k = 0; k < D; k++) begin
      tap_sel_i = TW'(k);
      #1;
      checks++;
      if ({tap_valid_o, tap_o} !== {1'b1, 18'(D - k)} || {tap_valid_o, tap_o} !== exp_tap(k)) begin
        failures++;
        $display("FAIL tap_sel%0d: got %h expected %h", k, {tap_valid_o, tap_o}, {1'b1, 18'(D - k)});
      end
    end
    #1 rst = 1'b1;
    #1;
    model_clear();
    checks++;
    if ({tap_valid_o, tap_o} !== 19'h0 || w_status !== {1'b0, 18'h0, 3'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL midrst: got tap=%h st=%h expected 0", {tap_valid_o, tap_o}, w_status);
    end
    #1 rst = 1'b0;
    for (int i = 0; i < D; i++) begin
      step(1'b1, 1'b0, 18'(300 + i), 1'b1);
      checks++;
      if (out_valid_o !== (i == D - 1) || w_status !== exp_status()) begin
        failures++;
        $display("FAIL post_rst_edge%0d: got %h expected %h", i + 1, w_status, exp_status());
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_hold();
    test_bubbles();
    test_clear();
    test_tap_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/e_delay_line.md
# e_delay_line

Parametrised enabled delay line: a chain of D enabled registers of width B, each carrying a valid bit, with synchronous clear, a selectable tap output and an occupancy counter. It generalises the single enabled register (E_REG) used across the datapath to a multi-stage, valid-tracked pipeline. Controllers use it to align operands across unequal path latencies and to stall (hold) the whole chain with one enable.

## Interface
- B, 18, data width in bits (B >= 1)
- D, 4, number of stages (D >= 2)
- Derived: TW = $clog2(D) tap-select width; CW = $clog2(D+1) count width

- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high; clears all state immediately
- en  input  1  shift enable; low = entire chain holds
- clr  input  1  synchronous clear of all valid bits and data; priority over en
- in  input  B  data into stage 0
- in_valid  input  1  valid bit into stage 0
- tap_sel  input  TW  stage index for tap outputs (0 = first stage)
- out  output  B  data of stage D-1 (registered)
- out_valid  output  1  valid bit of stage D-1
- tap  output  B  data of stage tap_sel (combinational mux of registers)
- tap_valid  output  1  valid bit of stage tap_sel
- count  output  CW  number of stages currently holding valid data, 0..D
- full  output  1  count == D
- empty  output  1  count == 0

## Operation
- State: data[0..D-1] (B bits each), valid[0..D-1], count (CW bits).
- Priority per rising edge: rst (async) > clr > en > hold.
- rst high: data, valid, count = 0 immediately, independent of clk; held at 0 while rst high.
- clr high (rst low): on the edge, data = 0, valid = 0, count = 0, regardless of en.
- en high (rst, clr low): data[0] <= in, valid[0] <= in_valid; data[i] <= data[i-1], valid[i] <= valid[i-1] for i = 1..D-1; stage D-1 contents discarded.
- Invalid words still shift: data moves with valid = 0; data is not zeroed.
- en low: all registers hold; in and in_valid ignored.
- count update on an en edge: count <= count + in_valid - valid[D-1]; both terms 1 -> unchanged. Never leaves 0..D by construction; no saturation logic.
- tap_sel >= D (possible when D is not a power of two): tap = 0, tap_valid = 0.
- full and empty are combinational decodes of count.

## Timing
- Latency: a word presented at an en-high edge appears on out after D en-high edges (D edges total if en held high); en-low cycles stretch latency one-for-one.
- tap at tap_sel = k shows the word after k+1 en edges.
- out, out_valid, count, full, empty change only on clk edges or on rst assertion; tap/tap_valid also follow tap_sel combinationally.
- Reset values: out = 0, out_valid = 0, tap = 0, tap_valid = 0, count = 0, full = 0, empty = 1.
- rst asserted mid-shift: all in-flight words lost; first valid output after release needs D more en edges.
- rst released: first capture on the first rising edge with rst low.
- clr and en in the same cycle: clear wins; in is not captured.
- Full chain with in_valid = 1 and en high: oldest word leaves via out, count stays D.

## Test plan
- Reset: B=18, D=4; drive in=12, en=0, assert rst at 17 ns for 12 ns -> out=0, out_valid=0, count=0, empty=1 immediately on rst rise, not at next edge.
- Fill/latency: en=1, in_valid=1, in=27 then 192, 5, 9 on successive edges -> out=27 with out_valid=1 on the 4th edge; count 1,2,3,4; full=1 after 4th edge; next edges out=192, 5, 9.
- Hold: after 2 valid words, en=0 for 3 cycles with in changing -> all outputs and count frozen; resume, 27 reaches out after 2 more en edges.
- Bubbles/count: pattern in_valid 1,0,1,0 into empty chain, en high -> count 1,1,2,2 then stays 2 while pattern repeats; out_valid alternates starting 4th edge.
- Clear priority: full chain, assert clr and en together with in=77, in_valid=1 -> after edge count=0, empty=1, all taps 0/invalid, 77 not captured.
- Tap and async reset mid-operation: tap_sel swept 0..3 after loading 1,2,3,4 -> tap = 4,3,2,1; then rst between edges -> tap=0, count=0 before next edge.
